// File: rtl/mul_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mul_tile_scheduler
// Purpose  : Walks a single row_col_multiplier across a T x T grid of m x m
//            output tiles in row-major order so that one multiplier produces
//            the full (T*m x n) x (n x T*m) product.
//            Local multiplier indices are offset into global A/B/R indices,
//            and result strobes are relayed to the result store as
//            registered writes while honouring store back-pressure.
// Ports    : clk, rst (async, active-high)
//            go / busy / done / tile_i / tile_j     controller side
//            mul_start / mul_clr / mul_done         multiplier control
//            mul_a_i / mul_b_j -> a_row / b_col     operand index offsetting
//            mul_z_i / mul_z_j -> cur_row / cur_col result index offsetting
//            mul_z_stb / mul_z_out / mul_z_ack      multiplier result handshake
//            r_wr_en / r_wr_row / r_wr_col / r_wr_data / r_wr_ready  store
// Config   : `define TILE_SCHED_PERF_EN adds perf_cycles / perf_stalls.
// Revision : 1.0  initial release
// ============================================================================
module mul_tile_scheduler #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int T     = 2,
  parameter int M_LEN = (M > 1) ? $clog2(M) : 1,
  parameter int G_LEN = ((T * M) > 1) ? $clog2(T * M) : 1,
  parameter int T_LEN = $clog2(T) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  output logic             busy,
  output logic             done,
  output logic [T_LEN-1:0] tile_i,
  output logic [T_LEN-1:0] tile_j,
  output logic             mul_start,
  output logic             mul_clr,
  input  logic             mul_done,
  input  logic [M_LEN-1:0] mul_a_i,
  input  logic [M_LEN-1:0] mul_b_j,
  input  logic [M_LEN-1:0] mul_z_i,
  input  logic [M_LEN-1:0] mul_z_j,
  input  logic             mul_z_stb,
  input  logic [31:0]      mul_z_out,
  output logic             mul_z_ack,
  output logic [G_LEN-1:0] a_row,
  output logic [G_LEN-1:0] b_col,
  output logic [G_LEN-1:0] cur_row,
  output logic [G_LEN-1:0] cur_col,
  output logic             r_wr_en,
  output logic [G_LEN-1:0] r_wr_row,
  output logic [G_LEN-1:0] r_wr_col,
  output logic [31:0]      r_wr_data,
  input  logic             r_wr_ready
`ifdef TILE_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stalls
`endif
);

  // Elaboration-time sanity check on the geometry.
  if ((N < 1) || (M < 1) || (T < 1)) begin : g_bad_params
    $error("mul_tile_scheduler: N, M and T must all be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_NEXT  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               start_q, start_d;
  logic               clr_q, clr_d;
  logic [T_LEN-1:0]   tile_i_q, tile_i_d;
  logic [T_LEN-1:0]   tile_j_q, tile_j_d;
  logic               ack_q, ack_d;
  logic               wr_en_q, wr_en_d;
  logic [G_LEN-1:0]   wr_row_q, wr_row_d;
  logic [G_LEN-1:0]   wr_col_q, wr_col_d;
  logic [31:0]        wr_data_q, wr_data_d;

  logic               w_run;
  logic               w_outstanding;
  logic               w_capture;

  // Global index = tile * M + local, computed wide then truncated; legal
  // parameters never exceed G_LEN bits.
  function automatic logic [G_LEN-1:0] glob_idx(input logic [T_LEN-1:0] t,
                                                input logic [M_LEN-1:0] l);
    return G_LEN'(32'(t) * 32'(M) + 32'(l));
  endfunction

  assign a_row   = glob_idx(tile_i_q, mul_a_i);
  assign b_col   = glob_idx(tile_j_q, mul_b_j);
  assign cur_row = glob_idx(tile_i_q, mul_z_i);
  assign cur_col = glob_idx(tile_j_q, mul_z_j);

  // A strobe still high during the ack cycle belongs to the write being
  // acknowledged, so it is neither outstanding nor captured again.
  assign w_run         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign w_outstanding = mul_z_stb & ~ack_q;
  assign w_capture     = w_run & w_outstanding & r_wr_ready;

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    start_d   = start_q;
    clr_d     = clr_q;
    tile_i_d  = tile_i_q;
    tile_j_d  = tile_j_q;

    ack_d     = w_capture;
    wr_en_d   = w_capture;
    wr_row_d  = w_capture ? cur_row   : wr_row_q;
    wr_col_d  = w_capture ? cur_col   : wr_col_q;
    wr_data_d = w_capture ? mul_z_out : wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d  = S_CLEAR;
          tile_i_d = '0;
          tile_j_d = '0;
          busy_d   = 1'b1;
          clr_d    = 1'b1;
        end
      end
      S_CLEAR: begin
        state_d = S_RUN;
        clr_d   = 1'b0;
        start_d = 1'b1;
      end
      S_RUN: begin
        if (mul_done) begin
          // A same-cycle strobe is captured above; DRAIN waits for its ack.
          state_d = w_outstanding ? S_DRAIN : S_NEXT;
          start_d = w_outstanding;
        end
      end
      S_DRAIN: begin
        if (!w_outstanding) begin
          state_d = S_NEXT;
          start_d = 1'b0;
        end
      end
      S_NEXT: begin
        if (tile_j_q < T_LEN'(T - 1)) begin
          tile_j_d = tile_j_q + T_LEN'(1);
          state_d  = S_CLEAR;
          clr_d    = 1'b1;
        end else if (tile_i_q < T_LEN'(T - 1)) begin
          tile_j_d = '0;
          tile_i_d = tile_i_q + T_LEN'(1);
          state_d  = S_CLEAR;
          clr_d    = 1'b1;
        end else begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        start_d = 1'b0;
        clr_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      clr_q     <= 1'b0;
      tile_i_q  <= '0;
      tile_j_q  <= '0;
      ack_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_q   <= start_d;
      clr_q     <= clr_d;
      tile_i_q  <= tile_i_d;
      tile_j_q  <= tile_j_d;
      ack_q     <= ack_d;
      wr_en_q   <= wr_en_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign tile_i    = tile_i_q;
  assign tile_j    = tile_j_q;
  assign mul_start = start_q;
  assign mul_clr   = clr_q;
  assign mul_z_ack = ack_q;
  assign r_wr_en   = wr_en_q;
  assign r_wr_row  = wr_row_q;
  assign r_wr_col  = wr_col_q;
  assign r_wr_data = wr_data_q;

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_stalls_q;

  // Counters restart when a new product is accepted and freeze once idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if ((state_q == S_IDLE) && go) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (busy_q) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
      if (w_run && mul_z_stb && !r_wr_ready) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_tile_scheduler
// Purpose  : Self-checking bench for mul_tile_scheduler. A behavioural
//            multiplier issues 16 results per tile in a random order with
//            random pacing and random store back-pressure; every result is
//            queued with its expected global coordinates and matched against
//            the store writes. A second instance with T=1 covers the
//            single-tile case.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_tile_scheduler;

  localparam int M  = 4;
  localparam int T  = 2;
  localparam int NT = T * T;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance (T=2) ----------------
  logic        rst, go, busy, done;
  logic [1:0]  tile_i, tile_j;
  logic        mul_start, mul_clr, mul_done;
  logic [1:0]  mul_a_i, mul_b_j, mul_z_i, mul_z_j;
  logic        mul_z_stb, mul_z_ack;
  logic [31:0] mul_z_out;
  logic [2:0]  a_row, b_col, cur_row, cur_col;
  logic        r_wr_en, r_wr_ready;
  logic [2:0]  r_wr_row, r_wr_col;
  logic [31:0] r_wr_data;
`ifdef TILE_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif

  mul_tile_scheduler #(.N(8), .M(M), .T(T)) u_dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done),
    .tile_i(tile_i), .tile_j(tile_j),
    .mul_start(mul_start), .mul_clr(mul_clr), .mul_done(mul_done),
    .mul_a_i(mul_a_i), .mul_b_j(mul_b_j), .mul_z_i(mul_z_i), .mul_z_j(mul_z_j),
    .mul_z_stb(mul_z_stb), .mul_z_out(mul_z_out), .mul_z_ack(mul_z_ack),
    .a_row(a_row), .b_col(b_col), .cur_row(cur_row), .cur_col(cur_col),
    .r_wr_en(r_wr_en), .r_wr_row(r_wr_row), .r_wr_col(r_wr_col),
    .r_wr_data(r_wr_data), .r_wr_ready(r_wr_ready)
`ifdef TILE_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  // ---------------- single-tile instance (T=1) ----------------
  logic        t1_go, t1_busy, t1_done, t1_start, t1_clr, t1_mul_done;
  logic [0:0]  t1_tile_i, t1_tile_j;
  logic [1:0]  t1_a_i, t1_b_j, t1_z_i, t1_z_j;
  logic        t1_stb, t1_ack, t1_wr_en, t1_ready;
  logic [31:0] t1_z_out, t1_wr_data;
  logic [1:0]  t1_a_row, t1_b_col, t1_cur_row, t1_cur_col, t1_wr_row, t1_wr_col;
`ifdef TILE_SCHED_PERF_EN
  logic [31:0] t1_perf_cycles, t1_perf_stalls;
`endif

  mul_tile_scheduler #(.N(8), .M(M), .T(1)) u_dut_t1 (
    .clk(clk), .rst(rst), .go(t1_go), .busy(t1_busy), .done(t1_done),
    .tile_i(t1_tile_i), .tile_j(t1_tile_j),
    .mul_start(t1_start), .mul_clr(t1_clr), .mul_done(t1_mul_done),
    .mul_a_i(t1_a_i), .mul_b_j(t1_b_j), .mul_z_i(t1_z_i), .mul_z_j(t1_z_j),
    .mul_z_stb(t1_stb), .mul_z_out(t1_z_out), .mul_z_ack(t1_ack),
    .a_row(t1_a_row), .b_col(t1_b_col), .cur_row(t1_cur_row), .cur_col(t1_cur_col),
    .r_wr_en(t1_wr_en), .r_wr_row(t1_wr_row), .r_wr_col(t1_wr_col),
    .r_wr_data(t1_wr_data), .r_wr_ready(t1_ready)
`ifdef TILE_SCHED_PERF_EN
    , .perf_cycles(t1_perf_cycles), .perf_stalls(t1_perf_stalls)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  typedef struct packed {
    logic [2:0]  row;
    logic [2:0]  col;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  cov [8][8];
  int  tile_seq_i [NT];
  int  tile_seq_j [NT];
  logic exp_en;
  int  m_cnt, stride, off;
  int  clr_cnt, done_cnt, busy_cycles, exp_stalls, stall_force;
  bit  done_seen;
  int  cur_ti, cur_tj;

  // One cycle of the reference: check what the DUT shows in the current
  // cycle, then decide the multiplier / store inputs for the same cycle.
  task automatic tick(input bit spam);
    wr_t  w;
    logic ack_seen;
    int   idx;
    @(negedge clk);
    check("wr_en", {31'd0, r_wr_en}, {31'd0, exp_en});
    check("z_ack", {31'd0, mul_z_ack}, {31'd0, exp_en});
    if (exp_en && r_wr_en && (exp_q.size() > 0)) begin
      w = exp_q.pop_front();
      check("wr_row", {29'd0, r_wr_row}, {29'd0, w.row});
      check("wr_col", {29'd0, r_wr_col}, {29'd0, w.col});
      check("wr_data", r_wr_data, w.data);
      cov[r_wr_row][r_wr_col]++;
    end
    if (mul_clr) begin
      if (clr_cnt < NT) begin
        check("clr_tile_i", {30'd0, tile_i}, tile_seq_i[clr_cnt]);
        check("clr_tile_j", {30'd0, tile_j}, tile_seq_j[clr_cnt]);
        check("clr_busy", {31'd0, busy}, 32'd1);
        check("clr_start", {31'd0, mul_start}, 32'd0);
        cur_ti = tile_seq_i[clr_cnt];
        cur_tj = tile_seq_j[clr_cnt];
      end else begin
        check("clr_count", clr_cnt + 1, NT);
      end
      clr_cnt++;
    end
    if (clr_cnt > 0) begin
      check("a_row", {29'd0, a_row}, cur_ti * M + int'(mul_a_i));
      check("b_col", {29'd0, b_col}, cur_tj * M + int'(mul_b_j));
      check("cur_row", {29'd0, cur_row}, cur_ti * M + int'(mul_z_i));
      check("cur_col", {29'd0, cur_col}, cur_tj * M + int'(mul_z_j));
    end
    if (!done_seen) busy_cycles++;
    if (done) begin
      done_cnt++;
      done_seen = 1'b1;
    end

    // multiplier behaviour
    ack_seen = mul_z_ack;
    if (mul_clr) begin
      m_cnt     = 0;
      mul_done  = 1'b0;
      mul_z_stb = 1'b0;
      stride    = int'($urandom % 8) * 2 + 1;
      off       = int'($urandom % 16);
    end else if (ack_seen) begin
      mul_z_stb = 1'b0;
    end else if (!mul_z_stb && mul_start && (m_cnt < M * M) && ($urandom % 3 != 0)) begin
      idx       = (m_cnt * stride + off) % 16;
      mul_z_i   = idx[3:2];
      mul_z_j   = idx[1:0];
      mul_z_out = (cur_ti == 1 && cur_tj == 0 && idx[3:2] == 2'd3 && idx[1:0] == 2'd2)
                  ? 32'hDEAD_BEEF : $urandom;
      mul_z_stb = 1'b1;
      w.row  = 3'(cur_ti * M + int'(idx[3:2]));
      w.col  = 3'(cur_tj * M + int'(idx[1:0]));
      w.data = mul_z_out;
      exp_q.push_back(w);
      m_cnt++;
      if (m_cnt == M * M) mul_done = 1'b1;
      if (clr_cnt == 1 && m_cnt == 3) stall_force = 5;
    end

    if (stall_force > 0) begin
      r_wr_ready = 1'b0;
      stall_force--;
    end else begin
      r_wr_ready = ($urandom % 4) != 0;
    end
    if (mul_z_stb && !r_wr_ready) exp_stalls++;
    exp_en  = mul_z_stb && r_wr_ready && !exp_en;
    mul_a_i = 2'($urandom);
    mul_b_j = 2'($urandom);
    go      = (spam && clr_cnt > 0 && !done_seen) ? 1'($urandom) : 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) cov[r][c] = 0;
    exp_en      = 1'b0;
    m_cnt       = 0;
    clr_cnt     = 0;
    done_cnt    = 0;
    done_seen   = 1'b0;
    busy_cycles = 0;
    exp_stalls  = 0;
    stall_force = 0;
    mul_z_stb   = 1'b0;
    mul_done    = 1'b0;
    go          = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_start"}, {31'd0, mul_start}, 32'd0);
    check({tag, "_clr"},   {31'd0, mul_clr}, 32'd0);
    check({tag, "_ack"},   {31'd0, mul_z_ack}, 32'd0);
    check({tag, "_wr_en"}, {31'd0, r_wr_en}, 32'd0);
    check({tag, "_tile_i"}, {30'd0, tile_i}, 32'd0);
    check({tag, "_tile_j"}, {30'd0, tile_j}, 32'd0);
    check({tag, "_wr_row"}, {29'd0, r_wr_row}, 32'd0);
    check({tag, "_wr_col"}, {29'd0, r_wr_col}, 32'd0);
    check({tag, "_wr_data"}, r_wr_data, 32'd0);
`ifdef TILE_SCHED_PERF_EN
    check({tag, "_perf_cycles"}, perf_cycles, 32'd0);
    check({tag, "_perf_stalls"}, perf_stalls, 32'd0);
`endif
  endtask

  task automatic full_product(input bit spam);
    int budget;
    model_reset();
    go = 1'b1;
    budget = 3000;
    while (!done_seen && budget > 0) begin
      tick(spam);
      budget--;
    end
    check("done_timeout", {31'd0, done_seen}, 32'd1);
    tick(1'b0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    tick(1'b0);
    check("done_pulses", done_cnt, 1);
    check("tile_count", clr_cnt, NT);
    check("writes_left", exp_q.size(), 0);
    check("final_tile_i", {30'd0, tile_i}, T - 1);
    check("final_tile_j", {30'd0, tile_j}, T - 1);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        check($sformatf("cov_%0d_%0d", r, c), cov[r][c], 1);
`ifdef TILE_SCHED_PERF_EN
    check("perf_cycles", perf_cycles, busy_cycles);
    check("perf_stalls", perf_stalls, exp_stalls);
`endif
  endtask

  initial begin
    int budget;
    for (int k = 0; k < NT; k++) begin
      tile_seq_i[k] = k / T;
      tile_seq_j[k] = k % T;
    end
    cur_ti = 0;
    cur_tj = 0;
    rst = 1'b1;
    model_reset();
    r_wr_ready = 1'b0;
    mul_a_i = '0; mul_b_j = '0; mul_z_i = '0; mul_z_j = '0; mul_z_out = '0;
    t1_go = 1'b0; t1_mul_done = 1'b0; t1_stb = 1'b0; t1_ready = 1'b0;
    t1_a_i = '0; t1_b_j = '0; t1_z_i = '0; t1_z_j = '0; t1_z_out = '0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;

    // Full product with random pacing and back-pressure.
    full_product(1'b0);

    // Abort in the last tile, then restart while hammering go.
    model_reset();
    go = 1'b1;
    budget = 3000;
    while (!(clr_cnt == NT && m_cnt >= 5) && budget > 0) begin
      tick(1'b0);
      budget--;
    end
    check("abort_reached_tile", clr_cnt, NT);
    #2 rst = 1'b1;
    #1 check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    full_product(1'b1);

    // Single-tile instance: last strobe coincides with mul_done.
    @(negedge clk);
    t1_go = 1'b1;
    @(negedge clk);
    t1_go = 1'b0;
    check("t1_clr", {31'd0, t1_clr}, 32'd1);
    check("t1_busy", {31'd0, t1_busy}, 32'd1);
    @(negedge clk);
    check("t1_start", {31'd0, t1_start}, 32'd1);
    check("t1_clr_once", {31'd0, t1_clr}, 32'd0);
    t1_stb = 1'b1; t1_z_i = 2'd1; t1_z_j = 2'd2; t1_z_out = 32'h1234_5678;
    t1_mul_done = 1'b1; t1_ready = 1'b1; t1_a_i = 2'd3;
    @(negedge clk);
    check("t1_wr_en", {31'd0, t1_wr_en}, 32'd1);
    check("t1_ack", {31'd0, t1_ack}, 32'd1);
    check("t1_wr_row", {30'd0, t1_wr_row}, 32'd1);
    check("t1_wr_col", {30'd0, t1_wr_col}, 32'd2);
    check("t1_wr_data", t1_wr_data, 32'h1234_5678);
    check("t1_a_row", {30'd0, t1_a_row}, 32'd3);
    t1_stb = 1'b0; t1_mul_done = 1'b0;
    @(negedge clk);
    check("t1_wr_en_drop", {31'd0, t1_wr_en}, 32'd0);
    check("t1_done_early", {31'd0, t1_done}, 32'd0);
    check("t1_start_next", {31'd0, t1_start}, 32'd0);
    @(negedge clk);
    check("t1_done", {31'd0, t1_done}, 32'd1);
    @(negedge clk);
    check("t1_done_pulse", {31'd0, t1_done}, 32'd0);
    check("t1_busy_end", {31'd0, t1_busy}, 32'd0);
    check("t1_clr_end", {31'd0, t1_clr}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
